// File: rtl/memoria_de_dados_bytes.sv
// memoria_de_dados_bytes: byte-addressed data memory for the iZero MIPS datapath.
// Byte, halfword and word loads/stores (little-endian lanes), sign or zero
// extension on loads, registered read data with a one-cycle rvalid pulse and
// an error pulse for misaligned, reserved-size or out-of-range accesses.
// Optional build macro MEM_INIT_CLEAR_EN: adds a reset-time sweep that zeroes
// every word before the memory reports ready.
module memoria_de_dados_bytes #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           datain,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           dataout,
  output logic                  error
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIW  = ADDR_WIDTH - 2;
  localparam logic [WIW-1:0]  DEPTH_W  = WIW'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

`ifdef MEM_INIT_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] f_byte_en(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it may land in.
  function automatic logic [31:0] f_store_lanes(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed lanes out of a word and extend them to 32 bits.
  function automatic logic [31:0] f_load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = u ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = u ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic [31:0] mem_q [DEPTH];

`ifndef MEM_INIT_CLEAR_EN
  // Without the clear sweep the array starts at zero in simulation only.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] = 32'h0000_0000;
    end
  end
`endif

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic           rvalid_q, rvalid_d;
  logic           error_q, error_d;
  logic [31:0]    dataout_q, dataout_d;
`ifdef MEM_INIT_CLEAR_EN
  logic [IDXW-1:0] cnt_q, cnt_d;
`endif

  logic [WIW-1:0]  word_idx_s;
  logic [1:0]      lane_s;
  logic            align_bad_s;
  logic            range_bad_s;
  logic            illegal_s;
  logic            accept_s;
  logic [IDXW-1:0] rd_idx_s;
  logic [31:0]     rd_word_s;
  logic            mem_we_s;
  logic [3:0]      mem_be_s;
  logic [IDXW-1:0] mem_widx_s;
  logic [31:0]     mem_wdata_s;

  assign word_idx_s  = addr[ADDR_WIDTH-1:2];
  assign lane_s      = addr[1:0];
  assign range_bad_s = (word_idx_s >= DEPTH_W);
  assign illegal_s   = align_bad_s | range_bad_s;
  assign accept_s    = req & ready_q;
  // Illegal indices may alias outside the array, so they read word 0 instead.
  assign rd_idx_s    = illegal_s ? {IDXW{1'b0}} : word_idx_s[IDXW-1:0];
  assign rd_word_s   = mem_q[rd_idx_s];

  // Size/alignment legality of the current request.
  always_comb begin
    align_bad_s = 1'b0;
    case (size)
      2'b00:   align_bad_s = 1'b0;
      2'b01:   align_bad_s = addr[0];
      2'b10:   align_bad_s = (addr[1:0] != 2'b00);
      default: align_bad_s = 1'b1;
    endcase
  end

  // Next state, array write request and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    rvalid_d    = 1'b0;
    error_d     = 1'b0;
    dataout_d   = dataout_q;
    mem_we_s    = 1'b0;
    mem_be_s    = 4'b0000;
    mem_widx_s  = {IDXW{1'b0}};
    mem_wdata_s = 32'h0000_0000;
`ifdef MEM_INIT_CLEAR_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef MEM_INIT_CLEAR_EN
        mem_we_s    = 1'b1;
        mem_be_s    = 4'b1111;
        mem_widx_s  = cnt_q;
        mem_wdata_s = 32'h0000_0000;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = {IDXW{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (accept_s) begin
          if (we) begin
            if (illegal_s) begin
              error_d = 1'b1;
            end else begin
              mem_we_s    = 1'b1;
              mem_be_s    = f_byte_en(size, lane_s);
              mem_widx_s  = word_idx_s[IDXW-1:0];
              mem_wdata_s = f_store_lanes(size, datain);
            end
          end else begin
            rvalid_d  = 1'b1;
            error_d   = illegal_s;
            dataout_d = illegal_s ? 32'h0000_0000 : f_load_extract(rd_word_s, size, lane_s, uns);
          end
        end else begin
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign ready_d = (state_d == ST_RUN);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      error_q   <= 1'b0;
      dataout_q <= 32'h0000_0000;
`ifdef MEM_INIT_CLEAR_EN
      cnt_q     <= {IDXW{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      error_q   <= error_d;
      dataout_q <= dataout_d;
`ifdef MEM_INIT_CLEAR_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Array write port; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_s[i]) begin
          mem_q[mem_widx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign ready   = ready_q;
  assign rvalid  = rvalid_q;
  assign error   = error_q;
  assign dataout = dataout_q;

endmodule
